// File: rtl/hazard_pkg.sv
// Shared constants and types for the multi-cycle hazard unit: forwarding selects,
// MDU controller states and default geometry.
package hazard_pkg;

    localparam int REG_AW_DEF  = 5;
    localparam int MDU_LAT_DEF = 4;
    localparam int CNT_W_DEF   = 4;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline-side bundle of the hazard unit: register fields and enables from D/E/M/W,
// MDU issue info in, and forwarding, stall and MDU status back out.
interface hazard_unit_mc_if
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
);

    logic [REG_AW-1:0] rsD, rtD;
    logic [REG_AW-1:0] rsE, rtE;
    logic [REG_AW-1:0] rwE, rwM, rwW;
    logic              RegWriteE, RegWriteM, RegWriteW;
    logic              MemtoRegE, MemtoRegM;
    logic              npc_selD;
    logic              mdu_opD;
    logic              mdu_startE;
    logic [REG_AW-1:0] mdu_rwE;

    logic [1:0]        ForwardAE, ForwardBE;
    logic              ForwardAD, ForwardBD;
    logic              StallF, StallD, FlushE;
    logic              mdu_busy;
    logic              mdu_done;
    logic [REG_AW-1:0] mdu_rw;
    logic [31:0]       stall_cnt;

    // datapath side
    modport master (
        output rsD, rtD, rsE, rtE, rwE, rwM, rwW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               npc_selD, mdu_opD, mdu_startE, mdu_rwE,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, FlushE, mdu_busy, mdu_done, mdu_rw, stall_cnt
    );

    // hazard unit side
    modport slave (
        input  rsD, rtD, rsE, rtE, rwE, rwM, rwW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               npc_selD, mdu_opD, mdu_startE, mdu_rwE,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, FlushE, mdu_busy, mdu_done, mdu_rw, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending bits for in-flight MDU results; one set port, one clear port,
// two combinational read ports. Register 0 is never marked.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    output logic              pa,
    output logic              pb
);

    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0] pending;

    // set is applied after clear so a reissue to the retiring register keeps it pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            if (clr_en) begin
                pending[clr_addr] <= 1'b0;
            end
            if (set_en && (set_addr != '0)) begin
                pending[set_addr] <= 1'b1;
            end
        end
    end

    assign pa = pending[ra];
    assign pb = pending[rb];

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage core with a multi-cycle MDU: forwarding, load-use/branch
// stalls, MDU scoreboard and latency FSM. Optional stall counter under HAZ_PERF_EN.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | no op in flight; may also be the done cycle of the last op
//  BUSY  | op in flight, cnt counts down to 1, then the done cycle follows
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MDU_LAT = MDU_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    hazard_unit_mc_if.slave        hif
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdu_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              busy_q;
    logic              done_q;
    logic [REG_AW-1:0] rw_q;

    logic [1:0]        fwd_ae, fwd_be;
    logic              fwd_ad, fwd_bd;
    logic              rs_nz, rt_nz;
    logic              lwstall, brstall, rawstall, strstall, stall;
    logic              mdu_accept;
    logic              done_next;
    logic              pend_rs, pend_rt;

    assign rs_nz = (hif.rsD != '0);
    assign rt_nz = (hif.rtD != '0);

    always_comb begin
        fwd_ae = FWD_REG;
        if ((hif.rsE != '0) && hif.RegWriteM && (hif.rsE == hif.rwM)) begin
            fwd_ae = FWD_M;
        end else if ((hif.rsE != '0) && hif.RegWriteW && (hif.rsE == hif.rwW)) begin
            fwd_ae = FWD_W;
        end
    end

    always_comb begin
        fwd_be = FWD_REG;
        if ((hif.rtE != '0) && hif.RegWriteM && (hif.rtE == hif.rwM)) begin
            fwd_be = FWD_M;
        end else if ((hif.rtE != '0) && hif.RegWriteW && (hif.rtE == hif.rwW)) begin
            fwd_be = FWD_W;
        end
    end

    assign fwd_ad = rs_nz && hif.RegWriteM && (hif.rsD == hif.rwM);
    assign fwd_bd = rt_nz && hif.RegWriteM && (hif.rtD == hif.rwM);

    assign lwstall = hif.MemtoRegE && (hif.rtE != '0) &&
                     ((hif.rsD == hif.rtE) || (hif.rtD == hif.rtE));

    // the compare in D needs operands that are still in E, or a load result still in M
    assign brstall = hif.npc_selD && (
                       (hif.RegWriteE && (hif.rwE != '0) &&
                        ((hif.rwE == hif.rsD) || (hif.rwE == hif.rtD))) ||
                       (hif.MemtoRegM && (hif.rwM != '0) &&
                        ((hif.rwM == hif.rsD) || (hif.rwM == hif.rtD))));

    assign rawstall  = pend_rs || pend_rt;
    assign done_next = (cnt == CNT_ONE);
    assign strstall  = hif.mdu_opD && busy_q && !done_next;
    assign stall     = lwstall || brstall || rawstall || strstall;

    // IDLE covers the done cycle, so a back-to-back issue is accepted there
    assign mdu_accept = hif.mdu_startE && (state == IDLE);

    hazard_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (mdu_accept),
        .set_addr (hif.mdu_rwE),
        .clr_en   (done_q),
        .clr_addr (rw_q),
        .ra       (hif.rsD),
        .rb       (hif.rtD),
        .pa       (pend_rs),
        .pb       (pend_rt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rw_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (hif.mdu_startE) begin
                        state  <= BUSY;
                        cnt    <= CNT_LOAD;
                        rw_q   <= hif.mdu_rwE;
                        busy_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (done_next) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    mdu_start_while_busy: assert property (
        @(posedge clk) disable iff (!rst) !(hif.mdu_startE && (state == BUSY))
    );

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign hif.stall_cnt = stall_cnt_q;
`else
    assign hif.stall_cnt = '0;
`endif

    assign hif.ForwardAE = fwd_ae;
    assign hif.ForwardBE = fwd_be;
    assign hif.ForwardAD = fwd_ad;
    assign hif.ForwardBD = fwd_bd;
    assign hif.StallF    = stall;
    assign hif.StallD    = stall;
    assign hif.FlushE    = stall;
    assign hif.mdu_busy  = busy_q;
    assign hif.mdu_done  = done_q;
    assign hif.mdu_rw    = rw_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc with MDU_LAT=4; expected stall_cnt depends on HAZ_PERF_EN.
module tb_hazard_unit_mc;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

`ifdef HAZ_PERF_EN
    localparam logic [31:0] EXP_PERF = 32'd7;
`else
    localparam logic [31:0] EXP_PERF = 32'd0;
`endif

    hazard_unit_mc_if #(.REG_AW(5)) hif ();

    hazard_unit_mc #(
        .REG_AW  (5),
        .MDU_LAT (4),
        .CNT_W   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, "_StallF"}, {31'd0, hif.StallF}, {31'd0, exp});
        chk({tag, "_StallD"}, {31'd0, hif.StallD}, {31'd0, exp});
        chk({tag, "_FlushE"}, {31'd0, hif.FlushE}, {31'd0, exp});
    endtask

    task automatic chk_mdu(input string tag, input logic busy, input logic done);
        chk({tag, "_busy"}, {31'd0, hif.mdu_busy}, {31'd0, busy});
        chk({tag, "_done"}, {31'd0, hif.mdu_done}, {31'd0, done});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hif.rsD = '0; hif.rtD = '0; hif.rsE = '0; hif.rtE = '0;
        hif.rwE = '0; hif.rwM = '0; hif.rwW = '0;
        hif.RegWriteE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
        hif.MemtoRegE = 1'b0; hif.MemtoRegM = 1'b0;
        hif.npc_selD = 1'b0; hif.mdu_opD = 1'b0;
        hif.mdu_startE = 1'b0; hif.mdu_rwE = '0;
    endtask

    initial begin
        clr();
        tick();
        tick();
        chk_mdu("rst", 1'b0, 1'b0);
        chk("rst_mdu_rw", {27'd0, hif.mdu_rw}, 32'd0);
        chk("rst_stall_cnt", hif.stall_cnt, 32'd0);
        chk_stall("rst", 1'b0);
        rst = 1'b1;
        tick();

        // forwarding
        hif.rsE = 5'd3; hif.rwM = 5'd3; hif.RegWriteM = 1'b1; hif.rwW = 5'd3; hif.RegWriteW = 1'b1;
        #1 chk("fwdAE_M", {30'd0, hif.ForwardAE}, 32'd2);
        hif.RegWriteM = 1'b0;
        #1 chk("fwdAE_W", {30'd0, hif.ForwardAE}, 32'd1);
        hif.rsE = 5'd0; hif.rwW = 5'd0;
        #1 chk("fwdAE_r0", {30'd0, hif.ForwardAE}, 32'd0);
        hif.rtE = 5'd3; hif.rwW = 5'd3; hif.RegWriteM = 1'b1;
        #1 chk("fwdBE_M", {30'd0, hif.ForwardBE}, 32'd2);
        hif.rtE = 5'd9;
        #1 chk("fwdBE_none", {30'd0, hif.ForwardBE}, 32'd0);
        hif.rsD = 5'd3; hif.rtD = 5'd4;
        #1 chk("fwdAD", {31'd0, hif.ForwardAD}, 32'd1);
        chk("fwdBD", {31'd0, hif.ForwardBD}, 32'd0);
        hif.rsD = 5'd0; hif.rwM = 5'd0;
        #1 chk("fwdAD_r0", {31'd0, hif.ForwardAD}, 32'd0);
        chk_stall("fwd", 1'b0);
        clr();

        // branch compare against an ALU result in E (comb only, no edge)
        hif.npc_selD = 1'b1; hif.rsD = 5'd4; hif.RegWriteE = 1'b1; hif.rwE = 5'd4;
        #1 chk_stall("br_E", 1'b1);
        hif.RegWriteE = 1'b0;
        #1 chk_stall("br_E_off", 1'b0);
        clr();
        tick();

        // load-use, then branch against the load in M
        hif.MemtoRegE = 1'b1; hif.RegWriteE = 1'b1; hif.rtE = 5'd5; hif.rwE = 5'd5; hif.rsD = 5'd5;
        #1 chk_stall("lw", 1'b1);
        tick();
        hif.MemtoRegE = 1'b0; hif.RegWriteE = 1'b0; hif.rtE = 5'd0; hif.rwE = 5'd0;
        hif.rwM = 5'd5; hif.MemtoRegM = 1'b1; hif.RegWriteM = 1'b1;
        #1 chk_stall("lw_after", 1'b0);
        hif.npc_selD = 1'b1;
        #1 chk_stall("br_M", 1'b1);
        tick();
        hif.npc_selD = 1'b0; hif.rwM = 5'd0; hif.MemtoRegM = 1'b0; hif.RegWriteM = 1'b0;
        hif.rwW = 5'd5; hif.RegWriteW = 1'b1;
        #1 chk_stall("br_after", 1'b0);
        hif.rsD = 5'd0; hif.MemtoRegE = 1'b1; hif.rtE = 5'd6; hif.rtD = 5'd6;
        #1 chk_stall("lw_rt", 1'b1);
        tick();
        clr();
        #1 chk_stall("lw_rt_after", 1'b0);
        tick();

        // MDU latency and RAW: start at t
        hif.mdu_startE = 1'b1; hif.mdu_rwE = 5'd7;
        #1 chk_mdu("t0", 1'b0, 1'b0);
        tick();
        hif.mdu_startE = 1'b0; hif.mdu_rwE = 5'd0; hif.rsD = 5'd7;
        #1 chk_mdu("t1", 1'b1, 1'b0);
        chk("t1_rw", {27'd0, hif.mdu_rw}, 32'd7);
        chk_stall("t1", 1'b1);
        tick();
        chk_mdu("t2", 1'b1, 1'b0);
        chk_stall("t2", 1'b1);
        tick();
        chk_mdu("t3", 1'b1, 1'b0);
        chk_stall("t3", 1'b1);
        tick();
        chk_mdu("t4", 1'b1, 1'b1);
        chk_stall("t4", 1'b1);
        tick();
        chk_mdu("t5", 1'b0, 1'b0);
        chk_stall("t5", 1'b0);
        chk("perf", hif.stall_cnt, EXP_PERF);
        clr();
        tick();

        // structural stall and back-to-back issue to the same register
        hif.mdu_startE = 1'b1; hif.mdu_rwE = 5'd9;
        tick();
        hif.mdu_startE = 1'b0; hif.mdu_opD = 1'b1;
        #1 chk_stall("u1_str", 1'b1);
        tick();
        chk_stall("u2_str", 1'b1);
        tick();
        chk_stall("u3_str", 1'b0);
        tick();
        chk_mdu("u4", 1'b1, 1'b1);
        hif.mdu_opD = 1'b0; hif.mdu_startE = 1'b1; hif.mdu_rwE = 5'd9;
        tick();
        hif.mdu_startE = 1'b0; hif.rsD = 5'd9;
        #1 chk_mdu("u5", 1'b1, 1'b0);
        chk("u5_rw", {27'd0, hif.mdu_rw}, 32'd9);
        chk_stall("u5_pend", 1'b1);
        hif.rsD = 5'd0;
        tick();
        tick();
        chk_mdu("u7", 1'b1, 1'b0);
        tick();
        chk_mdu("u8", 1'b1, 1'b1);
        tick();
        hif.rsD = 5'd9;
        #1 chk_mdu("u9", 1'b0, 1'b0);
        chk_stall("u9_clear", 1'b0);
        clr();
        tick();

        // reset while BUSY at counter=2
        hif.mdu_startE = 1'b1; hif.mdu_rwE = 5'd11;
        tick();
        hif.mdu_startE = 1'b0; hif.rsD = 5'd11;
        tick();
        chk_stall("v2_pend", 1'b1);
        rst = 1'b0;
        #1 chk_mdu("v2_rst", 1'b0, 1'b0);
        chk_stall("v2_rst", 1'b0);
        chk("v2_rst_rw", {27'd0, hif.mdu_rw}, 32'd0);
        chk("v2_rst_cnt", hif.stall_cnt, 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_mdu("abort", 1'b0, 1'b0);
        end
        chk_stall("abort_end", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
